sort_pulse_gen: RTL and testbench

Trapezoidal pulse generator feeding the two-channel DAC output stage of the sorting system. On an accepted trigger it waits a programmable delay, ramps the channel-1 sample toward a signed amplitude, holds, and ramps back to zero. Channel 2 carries the saturated complement. Both channels are signed 14-bit, two's complement, zero-centred; offset binary conversion happens downstream.

---
 rtl/sort_pulse_pkg.sv | 20 ++
 rtl/ramp_step.sv | 34 +++
 rtl/sort_pulse_gen.sv | 147 ++++++++++++++
 tb/tb_sort_pulse_gen.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pulse_pkg.sv
// Shared types and defaults for the trapezoidal pulse generator.
package sort_pulse_pkg;

    localparam int DW = 14;
    localparam int CW = 16;
    localparam int MW = 16;

    // Full signed range of a 14-bit DAC sample.
    localparam int AMP_MAX = 8191;
    localparam int AMP_MIN = -8192;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RISE,
        HOLD,
        FALL
    } state_e;

endpackage

// File: rtl/ramp_step.sv
// Moves acc one step toward target without passing it; shared by the rise and fall phases.
module ramp_step #(
    parameter int DW = sort_pulse_pkg::DW
) (
    input  logic signed [DW-1:0] acc_i,
    input  logic signed [DW-1:0] target_i,
    input  logic        [DW-2:0] step_i,
    output logic signed [DW-1:0] next_o,
    output logic                 at_target_o
);

    logic        [DW-2:0] step_eff;
    logic signed [DW:0]   acc_x;
    logic signed [DW:0]   tgt_x;
    logic signed [DW:0]   up;
    logic signed [DW:0]   dn;

    always_comb begin
        step_eff = (step_i == '0) ? (DW-1)'(1) : step_i;
        // One extra bit so acc +/- step can never wrap before the clamp.
        acc_x    = {acc_i[DW-1], acc_i};
        tgt_x    = {target_i[DW-1], target_i};
        up       = acc_x + $signed({2'b00, step_eff});
        dn       = acc_x - $signed({2'b00, step_eff});
        next_o   = target_i;
        if (tgt_x > acc_x) begin
            if (up < tgt_x) next_o = up[DW-1:0];
        end else if (dn > tgt_x) begin
            next_o = dn[DW-1:0];
        end
        at_target_o = (next_o == target_i);
    end

endmodule

// File: rtl/sort_pulse_gen.sv
// Trapezoidal pulse generator: delay, ramp to amp, hold, ramp back to zero.
// channel2 is the saturated complement of channel1 for the two-channel DAC stage.
module sort_pulse_gen #(
    parameter int DW = sort_pulse_pkg::DW,
    parameter int CW = sort_pulse_pkg::CW,
    parameter int MW = sort_pulse_pkg::MW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    input  logic                 abort,
    input  logic signed [DW-1:0] cfg_amp,
    input  logic        [DW-2:0] cfg_step,
    input  logic        [CW-1:0] cfg_delay,
    input  logic        [CW-1:0] cfg_hold,
    output logic signed [DW-1:0] channel1,
    output logic signed [DW-1:0] channel2,
    output logic                 busy,
    output logic                 done,
    output logic        [MW-1:0] miss_cnt
);

    import sort_pulse_pkg::*;

    localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

    state_e               state_q, state_d;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic signed [DW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] ch2_q, ch2_d;
    logic                 done_q, done_d;
    logic        [MW-1:0] miss_q, miss_d;
    logic signed [DW-1:0] amp_q, amp_d;
    logic        [DW-2:0] step_q, step_d;
    logic        [CW-1:0] hold_q, hold_d;

    logic signed [DW-1:0] ramp_tgt;
    logic signed [DW-1:0] ramp_next;
    logic                 ramp_at;

    assign ramp_tgt = (state_q == FALL) ? '0 : amp_q;

    ramp_step #(.DW(DW)) u_ramp (
        .acc_i       (acc_q),
        .target_i    (ramp_tgt),
        .step_i      (step_q),
        .next_o      (ramp_next),
        .at_target_o (ramp_at)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no branch leaves a value unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        miss_d  = miss_q;
        amp_d   = amp_q;
        step_d  = step_q;
        hold_d  = hold_q;

        if (state_q != IDLE && trig && !(&miss_q)) miss_d = miss_q + MW'(1);

        case (state_q)
            IDLE: begin
                if (trig && !abort) begin
                    amp_d   = cfg_amp;
                    step_d  = cfg_step;
                    hold_d  = cfg_hold;
                    cnt_d   = cfg_delay;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = RISE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RISE: begin
                if (abort) begin
                    state_d = FALL;
                end else if (acc_q == amp_q) begin
                    state_d = HOLD;
                end else begin
                    acc_d = ramp_next;
                    if (ramp_at) begin
                        state_d = HOLD;
                        cnt_d   = hold_q;
                    end
                end
            end
            HOLD: begin
                if (abort || cnt_q == '0) state_d = FALL;
                else                      cnt_d   = cnt_q - CW'(1);
            end
            FALL: begin
                acc_d = ramp_next;
                if (ramp_at) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered from the same next value so both channels update on one edge.
        ch2_d = (acc_d == S_MIN) ? S_MAX : -acc_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ch2_q   <= '0;
            done_q  <= 1'b0;
            miss_q  <= '0;
            amp_q   <= '0;
            step_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ch2_q   <= ch2_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
            amp_q   <= amp_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
        end
    end

    assign channel1 = acc_q;
    assign channel2 = ch2_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign miss_cnt = miss_q;

endmodule

// File: tb/tb_sort_pulse_gen.sv
// Self-checking bench for sort_pulse_gen: directed vector table, hand-written corner
// sequences, and randomized traffic against a waveform-list reference model.
module tb_sort_pulse_gen;

    localparam int DW       = 14;
    localparam int CW       = 16;
    localparam int MW       = 4;
    localparam int MISS_MAX = (1 << MW) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_DELAY = 1;
    localparam int P_RISE  = 2;
    localparam int P_HOLD  = 3;
    localparam int P_FALL  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 trig;
    logic                 abort;
    logic signed [DW-1:0] cfg_amp;
    logic        [DW-2:0] cfg_step;
    logic        [CW-1:0] cfg_delay;
    logic        [CW-1:0] cfg_hold;
    logic signed [DW-1:0] channel1;
    logic signed [DW-1:0] channel2;
    logic                 busy;
    logic                 done;
    logic        [MW-1:0] miss_cnt;

    sort_pulse_gen #(.DW(DW), .CW(CW), .MW(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .abort     (abort),
        .cfg_amp   (cfg_amp),
        .cfg_step  (cfg_step),
        .cfg_delay (cfg_delay),
        .cfg_hold  (cfg_hold),
        .channel1  (channel1),
        .channel2  (channel2),
        .busy      (busy),
        .done      (done),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ch2_of(input int v);
        return (v == -(1 << (DW - 1))) ? (1 << (DW - 1)) - 1 : -v;
    endfunction

    task automatic check_outs(input string tag, input int e_ch1, input int e_busy, input int e_done);
        check({tag, "_ch1"},  int'(channel1), e_ch1);
        check({tag, "_ch2"},  int'(channel2), ch2_of(e_ch1));
        check({tag, "_busy"}, int'(busy),     e_busy);
        check({tag, "_done"}, int'(done),     e_done);
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k = 0;
        while (!done && k < max_cyc) begin
            tick();
            k++;
        end
        check(name, int'(done), 1);
    endtask

    // Directed vector table: inputs applied before an edge, outputs expected after it.
    typedef struct {
        bit trig;
        bit abort;
        int amp;
        int step;
        int dly;
        int hold;
        int e_ch1;
        bit e_busy;
        bit e_done;
    } vec_t;

    vec_t vecs[$];
    int sc_amp, sc_step, sc_dly, sc_hold;

    function automatic void tv(input bit t, input bit a, input int ch1, input bit b, input bit d);
        vec_t r;
        r.trig = t;  r.abort = a;
        r.amp = sc_amp;  r.step = sc_step;  r.dly = sc_dly;  r.hold = sc_hold;
        r.e_ch1 = ch1;  r.e_busy = b;  r.e_done = d;
        vecs.push_back(r);
    endfunction

    function automatic void set_sc(input int a, input int s, input int d, input int h);
        sc_amp = a;  sc_step = s;  sc_dly = d;  sc_hold = h;
    endfunction

    // Reference model: on acceptance the whole remaining waveform is laid out as a list
    // of (phase, sample, done) entries, one per edge; abort rewrites the remaining list.
    typedef struct {
        int ph;
        int v;
        bit dn;
    } samp_t;

    samp_t m_cur;
    samp_t m_fut[$];
    int    m_step;
    int    m_miss;

    function automatic int toward(input int v, input int t, input int s);
        if (t > v) return (v + s > t) ? t : v + s;
        return (v - s < t) ? t : v - s;
    endfunction

    function automatic void push(input int ph, input int v, input bit dn);
        samp_t s;
        s.ph = ph;  s.v = v;  s.dn = dn;
        m_fut.push_back(s);
    endfunction

    function automatic void push_fall(input int from, input int s);
        int v = from;
        push(P_FALL, v, 1'b0);
        do begin
            v = toward(v, 0, s);
            if (v == 0) push(P_IDLE, 0, 1'b1);
            else        push(P_FALL, v, 1'b0);
        end while (v != 0);
    endfunction

    function automatic void build(input int amp, input int s, input int d, input int h);
        int v;
        m_fut.delete();
        repeat (d + 1) push(P_DELAY, 0, 1'b0);
        push(P_RISE, 0, 1'b0);
        v = toward(0, amp, s);
        while (v != amp) begin
            push(P_RISE, v, 1'b0);
            v = toward(v, amp, s);
        end
        repeat (h + 1) push(P_HOLD, amp, 1'b0);
        push_fall(amp, s);
    endfunction

    function automatic void model_reset();
        m_cur.ph = P_IDLE;  m_cur.v = 0;  m_cur.dn = 1'b0;
        m_fut.delete();
        m_miss = 0;
        m_step = 1;
    endfunction

    function automatic void model_step(input bit r, input bit t, input bit a,
                                       input int amp, input int s, input int d, input int h);
        if (r) begin
            model_reset();
            return;
        end
        if (m_cur.ph != P_IDLE && t && m_miss < MISS_MAX) m_miss++;
        if (m_cur.ph == P_IDLE) begin
            if (t && !a) begin
                m_step = (s == 0) ? 1 : s;
                build(amp, m_step, d, h);
            end
        end else if (a) begin
            if (m_cur.ph == P_DELAY) begin
                m_fut.delete();
                push(P_IDLE, 0, 1'b1);
            end else if (m_cur.ph == P_RISE || m_cur.ph == P_HOLD) begin
                m_fut.delete();
                push_fall(m_cur.v, m_step);
            end
        end
        if (m_fut.size() != 0) m_cur = m_fut.pop_front();
        else begin
            m_cur.ph = P_IDLE;  m_cur.v = 0;  m_cur.dn = 1'b0;
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        // Table contents.
        set_sc(1000, 250, 3, 2);
        tv(1, 0, 0, 1, 0);
        set_sc(-77, 9, 40, 40);               // late cfg changes must be ignored
        repeat (4) tv(0, 0, 0, 1, 0);
        tv(0, 0, 250, 1, 0);  tv(0, 0, 500, 1, 0);  tv(0, 0, 750, 1, 0);
        repeat (4) tv(0, 0, 1000, 1, 0);
        tv(0, 0, 750, 1, 0);  tv(0, 0, 500, 1, 0);  tv(0, 0, 250, 1, 0);
        tv(0, 0, 0, 0, 1);    tv(0, 0, 0, 0, 0);

        set_sc(-8192, 3000, 0, 0);
        tv(1, 0, 0, 1, 0);      tv(0, 0, 0, 1, 0);
        tv(0, 0, -3000, 1, 0);  tv(0, 0, -6000, 1, 0);
        tv(0, 0, -8192, 1, 0);  tv(0, 0, -8192, 1, 0);
        tv(0, 0, -5192, 1, 0);  tv(0, 0, -2192, 1, 0);
        tv(0, 0, 0, 0, 1);      tv(0, 0, 0, 0, 0);

        set_sc(0, 100, 0, 0);
        tv(1, 0, 0, 1, 0);
        repeat (3) tv(0, 0, 0, 1, 0);
        tv(0, 0, 0, 0, 1);  tv(0, 0, 0, 0, 0);

        set_sc(1000, 250, 0, 5);               // abort in HOLD
        tv(1, 0, 0, 1, 0);    tv(0, 0, 0, 1, 0);
        tv(0, 0, 250, 1, 0);  tv(0, 0, 500, 1, 0);  tv(0, 0, 750, 1, 0);
        tv(0, 0, 1000, 1, 0); tv(0, 0, 1000, 1, 0);
        tv(0, 1, 1000, 1, 0);
        tv(0, 0, 750, 1, 0);  tv(0, 0, 500, 1, 0);  tv(0, 0, 250, 1, 0);
        tv(0, 0, 0, 0, 1);    tv(0, 0, 0, 0, 0);

        set_sc(1000, 250, 5, 0);               // abort in DELAY
        tv(1, 0, 0, 1, 0);  tv(0, 0, 0, 1, 0);
        tv(0, 1, 0, 0, 1);  tv(0, 0, 0, 0, 0);

        set_sc(500, 100, 0, 0);                // abort in IDLE blocks trig
        tv(1, 1, 0, 0, 0);  tv(0, 0, 0, 0, 0);

        set_sc(2, 0, 1, 0);                    // step 0 acts as 1
        repeat (3) tv(i_first(), 0, 0, 1, 0);
        tv(0, 0, 1, 1, 0);  tv(0, 0, 2, 1, 0);  tv(0, 0, 2, 1, 0);
        tv(0, 0, 1, 1, 0);  tv(0, 0, 0, 0, 1);  tv(0, 0, 0, 0, 0);

        set_sc(-1000, 300, 0, 3);              // abort in RISE
        tv(1, 0, 0, 1, 0);  tv(0, 0, 0, 1, 0);  tv(0, 0, -300, 1, 0);
        tv(0, 1, -300, 1, 0);
        tv(0, 0, 0, 0, 1);  tv(0, 0, 0, 0, 0);

        set_sc(600, 200, 0, 0);                // abort in FALL is ignored
        tv(1, 0, 0, 1, 0);  tv(0, 0, 0, 1, 0);
        tv(0, 0, 200, 1, 0);  tv(0, 0, 400, 1, 0);
        tv(0, 0, 600, 1, 0);  tv(0, 0, 600, 1, 0);
        tv(0, 1, 400, 1, 0);  tv(0, 0, 200, 1, 0);
        tv(0, 0, 0, 0, 1);    tv(0, 0, 0, 0, 0);

        // Reset state.
        rst = 1'b1;  trig = 1'b0;  abort = 1'b0;
        cfg_amp = '0;  cfg_step = '0;  cfg_delay = '0;  cfg_hold = '0;
        tick();
        tick();
        check_outs("reset", 0, 0, 0);
        check("reset_miss", int'(miss_cnt), 0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            trig      = vecs[i].trig;
            abort     = vecs[i].abort;
            cfg_amp   = DW'(vecs[i].amp);
            cfg_step  = (DW-1)'(vecs[i].step);
            cfg_delay = CW'(vecs[i].dly);
            cfg_hold  = CW'(vecs[i].hold);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_ch1, vecs[i].e_busy, vecs[i].e_done);
            check($sformatf("vec%0d_miss", i), int'(miss_cnt), 0);
        end
        trig = 1'b0;  abort = 1'b0;

        // Trig held for 10 cycles from acceptance: 9 of them land while busy.
        cfg_amp = 14'sd1000;  cfg_step = 13'd250;  cfg_delay = 16'd3;  cfg_hold = 16'd2;
        trig = 1'b1;
        repeat (10) tick();
        trig = 1'b0;
        check("miss_9", int'(miss_cnt), 9);
        wait_done("miss_pulse_done", 40);
        tick();
        check("miss_idle_busy", int'(busy), 0);

        // Trig held across a whole pulse: counter saturates, retrigger on the done cycle.
        trig = 1'b1;
        wait_done("retrig_first_done", 40);
        check("miss_sat", int'(miss_cnt), MISS_MAX);
        tick();
        check("retrig_busy", int'(busy), 1);
        check("retrig_done_low", int'(done), 0);
        check("retrig_ch1", int'(channel1), 0);
        repeat (5) tick();
        check("miss_sat_hold", int'(miss_cnt), MISS_MAX);
        trig = 1'b0;
        wait_done("retrig_second_done", 40);
        tick();

        // Synchronous reset in the middle of RISE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_delay = 16'd0;  cfg_hold = 16'd0;
        trig = 1'b1;
        repeat (3) tick();
        trig = 1'b0;
        tick();
        check("midrise_ch1", int'(channel1), 500);
        check("midrise_miss", int'(miss_cnt), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("midrise_rst", 0, 0, 0);
        check("midrise_rst_miss", int'(miss_cnt), 0);

        // Randomized traffic against the reference model.
        rst = 1'b1;  trig = 1'b0;  abort = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 399) == 0);
            trig  = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) begin
                a = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) a = -a;
                cfg_step = '0;
            end else begin
                do a = int'($urandom_range(0, 16383)) - 8192; while (a == 0);
                cfg_step = (DW-1)'($urandom_range(150, 8191));
            end
            cfg_amp   = DW'(a);
            cfg_delay = CW'($urandom_range(0, 6));
            cfg_hold  = CW'($urandom_range(0, 6));
            model_step(rst, trig, abort, a, int'(cfg_step), int'(cfg_delay), int'(cfg_hold));
            tick();
            check_outs($sformatf("rnd%0d", c), m_cur.v, (m_cur.ph != P_IDLE) ? 1 : 0, int'(m_cur.dn));
            check($sformatf("rnd%0d_miss", c), int'(miss_cnt), m_miss);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Only the first vector of the step-0 scenario carries a trigger.
    int first_cnt = 0;
    function automatic bit i_first();
        first_cnt++;
        return (first_cnt == 1);
    endfunction

endmodule
